hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. It owns all stall, flush and forward-select decisions around the decode-stage register file and the E/M/W forwarding muxes. It also sequences a multi-cycle multiply/divide unit through a busy FSM, so that HI/LO consumers and new mul/div ops are held in Decode until the result is written. Write-back-to-decode bypass is already resolved inside the decode stage; this block never forwards W into D.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_ctrl_if.sv | 47 ++++
 rtl/muldiv_seq.sv | 70 +++++++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - forward-select encodings for the E-stage operand muxes
//   - mul/div sequencer state type
//   - default mul/div latency and counter width
//   - reg_match(): register-number compare where r0 never matches
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
   localparam logic [1:0] FWD_WB  = 2'b01;  // operand from ResultW
   localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUOutM

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_BUSY,
      MD_DONE
   } md_state_t;

   localparam int unsigned MULDIV_LAT_DEFAULT = 32;
   localparam int unsigned CNT_W_DEFAULT      = 6;

   // r0 is hardwired to zero, so it must never produce a hazard or a forward.
   function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   master modport: pipeline side, drives stage fields and sees stall/flush/forward selects.
//   slave modport : hazard_ctrl side.
// With HAZARD_PERF_EN defined, the bundle also carries the StallCycles, FlushCount and
// MDCycles performance counters.
interface hazard_ctrl_if;

   logic [4:0] RsD, RtD;
   logic [4:0] RsE, RtE;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemtoRegE, MemtoRegM;
   logic       BranchD, PCSrcD, JumpD;
   logic       MulDivD, HiLoReadD, MulDivStartE;

   logic       StallF, StallD;
   logic       FlushD, FlushE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD;
   logic       MDBusy, MDDone;
`ifdef HAZARD_PERF_EN
   logic [31:0] StallCycles, FlushCount, MDCycles;
`endif

   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
      output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
      output BranchD, PCSrcD, JumpD, MulDivD, HiLoReadD, MulDivStartE,
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
      input  ForwardAD, ForwardBD, MDBusy, MDDone
`ifdef HAZARD_PERF_EN
      , input StallCycles, FlushCount, MDCycles
`endif
   );

   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
      input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
      input  BranchD, PCSrcD, JumpD, MulDivD, HiLoReadD, MulDivStartE,
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
      output ForwardAD, ForwardBD, MDBusy, MDDone
`ifdef HAZARD_PERF_EN
      , output StallCycles, FlushCount, MDCycles
`endif
   );

endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: occupancy sequencer for the multi-cycle mul/div unit.
//   CLK   in  clock, rising edge
//   RST   in  synchronous active-high reset (returns to IDLE, no done strobe)
//   start in  one-cycle start pulse; ignored unless IDLE
//   busy  out state != IDLE
//   done  out one-cycle HI/LO write strobe (DONE state)
// Occupancy after start is MULDIV_LAT cycles: MULDIV_LAT-1 in BUSY plus one in DONE.
module muldiv_seq
   import hazard_pkg::*;
#(
   parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT,
   parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
   input  logic CLK,
   input  logic RST,
   input  logic start,
   output logic busy,
   output logic done
);

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               state_d = MD_BUSY;
               // BUSY spans counts LAT-2 down to 0, i.e. LAT-1 cycles.
               cnt_d   = CNT_W'(MULDIV_LAT - 2);
            end
         end
         MD_BUSY: begin
            if (cnt_q == '0) begin
               state_d = MD_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         MD_DONE: begin
            state_d = MD_IDLE;
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs.
   always_comb begin
      busy = (state_q != MD_IDLE);
      done = (state_q == MD_DONE);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / forward-select control for the 5-stage MIPS pipeline,
// plus sequencing of the multi-cycle mul/div unit.
//   CLK  in    clock, rising edge
//   RST  in    synchronous active-high reset
//   hif  slave hazard_ctrl_if: stage register fields and write enables in;
//              StallF/StallD, FlushD/FlushE, ForwardAE/BE (2b), ForwardAD/BD,
//              MDBusy, MDDone out.
// Optional macro HAZARD_PERF_EN adds StallCycles, FlushCount and MDCycles counters.
// W->D bypass lives in the decode stage, so no W forward is produced for Decode.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT,
   parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
   input logic          CLK,
   input logic          RST,
   hazard_ctrl_if.slave hif
);

   logic md_busy, md_done;
   logic lwstall, brstall, mdstall, stall;
   logic redirect;

   muldiv_seq #(
      .MULDIV_LAT (MULDIV_LAT),
      .CNT_W      (CNT_W)
   ) u_muldiv_seq (
      .CLK   (CLK),
      .RST   (RST),
      .start (hif.MulDivStartE),
      .busy  (md_busy),
      .done  (md_done)
   );

   // Hazard detection.
   always_comb begin
      lwstall = hif.MemtoRegE &
                (reg_match(hif.RtE, hif.RsD) | reg_match(hif.RtE, hif.RtD));

      // Branch compare in D needs the value now: an E-stage ALU result or an M-stage
      // load cannot be forwarded in time.
      brstall = hif.BranchD &
                ((hif.RegWriteE &
                  (reg_match(hif.WriteRegE, hif.RsD) | reg_match(hif.WriteRegE, hif.RtD))) |
                 (hif.MemtoRegM &
                  (reg_match(hif.WriteRegM, hif.RsD) | reg_match(hif.WriteRegM, hif.RtD))));

      // DONE (busy & done) does not stall: HI/LO is written at the end of that cycle.
      mdstall  = (hif.MulDivD | hif.HiLoReadD) &
                 ((md_busy & ~md_done) | hif.MulDivStartE);

      stall    = lwstall | brstall | mdstall;
      redirect = (hif.PCSrcD | hif.JumpD) & ~stall;
   end

   // Control outputs; reset forces a quiet pipeline with a bubble in Execute.
   always_comb begin
      hif.StallF    = 1'b0;
      hif.StallD    = 1'b0;
      hif.FlushD    = 1'b0;
      hif.FlushE    = 1'b1;
      hif.ForwardAE = FWD_RF;
      hif.ForwardBE = FWD_RF;
      hif.ForwardAD = 1'b0;
      hif.ForwardBD = 1'b0;
      if (!RST) begin
         hif.StallF = stall;
         hif.StallD = stall;
         hif.FlushD = redirect;
         hif.FlushE = stall;

         // M has priority over W: it holds the younger result.
         if (hif.RegWriteM && reg_match(hif.RsE, hif.WriteRegM)) begin
            hif.ForwardAE = FWD_MEM;
         end else if (hif.RegWriteW && reg_match(hif.RsE, hif.WriteRegW)) begin
            hif.ForwardAE = FWD_WB;
         end

         if (hif.RegWriteM && reg_match(hif.RtE, hif.WriteRegM)) begin
            hif.ForwardBE = FWD_MEM;
         end else if (hif.RegWriteW && reg_match(hif.RtE, hif.WriteRegW)) begin
            hif.ForwardBE = FWD_WB;
         end

         hif.ForwardAD = hif.RegWriteM & reg_match(hif.RsD, hif.WriteRegM);
         hif.ForwardBD = hif.RegWriteM & reg_match(hif.RtD, hif.WriteRegM);
      end
   end

   always_comb begin
      hif.MDBusy = md_busy;
      hif.MDDone = md_done;
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;
   logic [31:0] md_cycles_q, md_cycles_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
         md_cycles_q    <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
         md_cycles_q    <= md_cycles_d;
      end
   end

   // Counters wrap naturally at 2^32.
   always_comb begin
      stall_cycles_d = stall_cycles_q + {31'd0, stall};
      flush_count_d  = flush_count_q + {31'd0, redirect};
      md_cycles_d    = md_cycles_q + {31'd0, md_busy};
   end

   always_comb begin
      hif.StallCycles = stall_cycles_q;
      hif.FlushCount  = flush_count_q;
      hif.MDCycles    = md_cycles_q;
   end
`endif

endmodule
